// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 opcodes, funct3 size encodings and MEM stage FSM state
package rv32_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} mem_state_t;
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        return (funct3[1:0] == SZ_H && addr[0]) || (funct3[1:0] == SZ_W && addr != 2'b00);
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane/strobe generation and load byte/half extraction with extension
module mem_align import rv32_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    // Replicate store data across lanes, pick load lanes and extend (funct3[2] selects unsigned)
    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = rdata[{addr[1], 4'b0000} +: 16];
        wstrb = funct3[1:0] == SZ_B ? 4'b0001 << addr :
                funct3[1:0] == SZ_H ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
        wdata = funct3[1:0] == SZ_B ? {4{store_data[7:0]}} :
                funct3[1:0] == SZ_H ? {2{store_data[15:0]}} : store_data;
        ldata = funct3[1:0] == SZ_B ? {{24{byte_sel[7] & ~funct3[2]}}, byte_sel} :
                funct3[1:0] == SZ_H ? {{16{half_sel[15] & ~funct3[2]}}, half_sel} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory stage (IDLE/REQ/WAIT) with writeback register.
// Define MEM_MISALIGN_TRAP_EN to add the misalign output and trap misaligned halfword/word ops.
module mem_stage import rv32_pkg::*; #(
    parameter int DMEM_AW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic               misalign,
`endif
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [6:0]         ex_opcode,
    input  logic [2:0]         ex_funct3,
    input  logic [4:0]         ex_rd_addr,
    input  logic [31:0]        ex_alu_result,
    input  logic [31:0]        ex_store_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_wstrb,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [31:0]        dmem_rdata,
    output logic               wb_valid,
    output logic [6:0]         wb_opcode,
    output logic [4:0]         wb_rd_addr,
    output logic [31:0]        wb_rd_data
);
    mem_state_t         state, state_n;
    logic               drop, drop_n, retire, accept, is_mem, is_load, trap;
    logic [6:0]         req_opcode;
    logic [2:0]         req_funct3;
    logic [4:0]         req_rd_addr;
    logic [DMEM_AW-1:0] req_addr;
    logic [31:0]        req_store_data, ldata;
    logic [3:0]         wstrb;

    assign accept  = ex_valid && state == S_IDLE && !flush;
    assign is_mem  = ex_opcode == OPC_LOAD || ex_opcode == OPC_STORE;
    assign is_load = req_opcode == OPC_LOAD;
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = accept && is_mem && misaligned(ex_funct3, ex_alu_result[1:0]);
`else
    assign trap = 1'b0;
`endif
    assign dmem_addr = {req_addr[DMEM_AW-1:2], 2'b00};

    mem_align u_align (
        .funct3     (req_funct3),
        .addr       (req_addr[1:0]),
        .store_data (req_store_data),
        .rdata      (dmem_rdata),
        .wstrb      (wstrb),
        .wdata      (dmem_wdata),
        .ldata      (ldata)
    );

    // Next state and handshake outputs; a load flushed after its grant waits out rvalid with drop set
    always_comb begin
        state_n    = state;
        drop_n     = drop;
        retire     = 1'b0;
        ex_ready   = state == S_IDLE;
        dmem_req   = state == S_REQ;
        dmem_we    = state == S_REQ && !is_load;
        dmem_wstrb = dmem_we ? wstrb : 4'b0000;
        case (state)
            S_IDLE: state_n = accept && is_mem && !trap ? S_REQ : S_IDLE;
            S_REQ: begin
                if (dmem_gnt && (!is_load || dmem_rvalid)) begin
                    state_n = S_IDLE;
                    retire  = !flush;
                end else if (dmem_gnt) begin
                    state_n = S_WAIT;
                    drop_n  = flush;
                end else if (flush) begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                state_n = dmem_rvalid ? S_IDLE : S_WAIT;
                retire  = dmem_rvalid && !drop && !flush;
                drop_n  = drop || flush;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM state and pending-drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
        end
    end

    // Captured op fields and the writeback entry (fields hold between pulses)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_opcode     <= '0;
            req_funct3     <= '0;
            req_rd_addr    <= '0;
            req_addr       <= '0;
            req_store_data <= '0;
            wb_valid       <= 1'b0;
            wb_opcode      <= '0;
            wb_rd_addr     <= '0;
            wb_rd_data     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign       <= 1'b0;
`endif
        end else begin
            wb_valid <= retire || (accept && !is_mem);
            if (accept) begin
                req_opcode     <= ex_opcode;
                req_funct3     <= ex_funct3;
                req_rd_addr    <= ex_rd_addr;
                req_addr       <= ex_alu_result[DMEM_AW-1:0];
                req_store_data <= ex_store_data;
            end
            if (accept && !is_mem) begin
                wb_opcode  <= ex_opcode;
                wb_rd_addr <= ex_rd_addr;
                wb_rd_data <= ex_alu_result;
            end else if (retire) begin
                wb_opcode  <= req_opcode;
                wb_rd_addr <= req_rd_addr;
                wb_rd_data <= is_load ? ldata : req_store_data;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= trap;
`endif
        end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DMEM_AW, default 32, data-memory byte-address width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  discard the current entry.
- ex_valid  in  1  EX result valid.
- ex_ready  out  1  stage can accept.
- ex_opcode  in  7  instruction opcode.
- ex_funct3  in  3  load/store size and sign.
- ex_rd_addr  in  5  destination register.
- ex_alu_result  in  32  ALU result, or effective address for memory ops.
- ex_store_data  in  32  rs2 value for stores.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  DMEM_AW  word-aligned address ([1:0]=0).
- dmem_wstrb  out  4  byte strobes.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- wb_valid  out  1  writeback entry valid.
- wb_opcode  out  7  opcode of the writeback entry; drives the forwarding unit.
- wb_rd_addr  out  5  destination register; drives the forwarding unit.
- wb_rd_data  out  32  result or aligned load data; drives the forwarding unit.

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT.
- ex_ready=1 only in IDLE.
REQ-004 Non-memory op accepted in IDLE SHALL appear on wb_* the next cycle (latency 1) with wb_rd_data=ex_alu_result.
REQ-005 Load/store accepted in IDLE SHALL register its fields and go to REQ.
- In REQ, dmem_req=1 and dmem_addr/we/wstrb/wdata are held stable until dmem_gnt.
REQ-006 Store, on dmem_gnt, SHALL go to IDLE and present wb_valid=1 with wb_opcode=OPC_STORE for one cycle.
REQ-007 Load, on dmem_gnt, SHALL go to WAIT.
- On dmem_rvalid it goes to IDLE and presents aligned data the next cycle.
- Same-cycle gnt+rvalid skips WAIT.
REQ-008 Store strobes SHALL be:
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<{addr[1],1'b0}.
- SW: 4'b1111.
- Data replicated across lanes.
REQ-009 Load alignment SHALL select the byte/half by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-010 wb_valid SHALL be a one-cycle pulse per retired entry.
- wb_opcode/rd_addr/rd_data hold their values until the next entry.
REQ-011 flush in IDLE/REQ SHALL drop the entry: no wb_valid, no dmem_req next cycle, return to IDLE.
REQ-012 flush in WAIT SHALL remain in WAIT until dmem_rvalid, then return to IDLE with no wb_valid.
REQ-013 flush and ex_valid in the same cycle SHALL not accept the new op.

Reset
REQ-014 While rst_n=0, the block SHALL hold:
- FSM=IDLE.
- dmem_req=0, dmem_we=0, dmem_wstrb=0, wb_valid=0.
- wb_opcode=0, wb_rd_addr=0, wb_rd_data=0.
REQ-015 Reset mid-transaction SHALL abandon it; any dmem_rvalid after release SHALL be ignored.

Configuration
REQ-016 With MEM_MISALIGN_TRAP_EN defined, the block SHALL:
- Add output misalign (1 bit).
- For a halfword at addr[0]=1 or a word at addr[1:0]!=0, pulse misalign in the accept cycle+1.
- Issue no dmem_req and produce no wb_valid for that op.
REQ-017 Without MEM_MISALIGN_TRAP_EN, the misalign port SHALL be absent and misaligned accesses SHALL use the masked address bits.

Structure
REQ-018 Shared package rv32_pkg SHALL hold:
- Opcode constants: OPC_LOAD, OPC_STORE, OPC_BRANCH.
- funct3 size encodings.
- FSM state typedef.
REQ-019 The design SHALL have one sub-module, mem_align: combinational store lane/strobe generation and load extraction/extension.

Verification
REQ-020 The bench SHALL cover:
- ADD rd=5, result 0x1234 -> next cycle wb_valid=1, wb_rd_addr=5, wb_rd_data=0x1234.
- LB addr 0x103, gnt after 2 cycles, rdata 0x80FF_FFFF -> wb_rd_data=0xFFFF_FF80; ex_ready=0 throughout.
- SH addr 0x202, data 0xABCD -> dmem_addr=0x200, wstrb=4'b1100, wdata=0xABCD_ABCD.
- LW in WAIT, flush, then rvalid -> no wb_valid; next op accepted after return to IDLE.
- rst_n low during REQ -> dmem_req=0 immediately; late rvalid ignored.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x6 -> misalign=1, dmem_req stays 0.
